branch_resolver: RTL and testbench

Execute-side counterpart of the decode-stage branch predictor. Records every branch prediction made in decode in an in-order queue. When execute resolves the oldest outstanding branch, it compares the actual outcome with the recorded prediction. It then drives the predictor's update interface (past_pc, past_is_branch, past_wrong, past_predicted_taken) and a front-end redirect/flush.

---
 rtl/branch_resolver_pkg.sv | 20 ++
 rtl/bp_fifo.sv | 65 ++++++
 rtl/branch_resolver.sv | 99 +++++++++
 tb/tb_branch_resolver.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the execute-side branch resolver.
package branch_resolver_pkg;

    localparam int BP_DEPTH  = 4;
    localparam int BP_PC_W   = 32;
    localparam int BP_PC_INC = 1;

    // Layout of one outstanding prediction, oldest field in the MSBs.
    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               pred_taken;
        logic [BP_PC_W-1:0] pred_target;
    } bp_entry_t;

    // Pointer width for a queue of the given depth (never narrower than 1 bit).
    function automatic int bp_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bp_fifo.sv
// Generic circular FIFO with push, pop and a flush that empties the queue
// after consuming the head entry. Pushes are refused when full unless a pop
// frees a slot in the same cycle, and are always refused during a flush.
module bp_fifo
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH,
    parameter int WIDTH = 2 * BP_PC_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = bp_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~flush & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Entry storage; contents need no reset because count guards every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; a flush collapses the queue behind the popped head.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= rd_ptr + PTR_W'(do_pop);
            wr_ptr <= rd_ptr + PTR_W'(do_pop);
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Records decode-stage branch predictions in order, compares each against the
// execute outcome, and drives the predictor update and front-end redirect.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH  = BP_DEPTH,
    parameter int PC_W   = BP_PC_W,
    parameter int PC_INC = BP_PC_INC
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            dec_push,
    input  logic [PC_W-1:0] dec_pc,
    input  logic            dec_pred_taken,
    input  logic [PC_W-1:0] dec_pred_target,
    input  logic            ex_resolve,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    output logic [PC_W-1:0] past_pc,
    output logic            past_is_branch,
    output logic            past_wrong,
    output logic            past_predicted_taken,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            queue_full,
    output logic            queue_empty,
    output logic            underflow_err
);

    // Entries use the bp_entry_t field order {pc, pred_taken, pred_target}.
    localparam int ENTRY_W = 2 * PC_W + 1;

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic [PC_W-1:0]    head_pc;
    logic               head_pred_taken;
    logic [PC_W-1:0]    head_target;
    logic               pop_ok;
    logic               wrong;
    logic               mispredict;
    logic [PC_W-1:0]    fix_pc;

    assign wr_entry        = {dec_pc, dec_pred_taken, dec_pred_target};
    assign head_pc         = head[ENTRY_W-1 -: PC_W];
    assign head_pred_taken = head[PC_W];
    assign head_target     = head[PC_W-1:0];
    assign pop_ok          = ex_resolve & ~queue_empty;

    bp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (dec_push),
        .pop     (ex_resolve),
        .flush   (mispredict),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (queue_full),
        .empty   (queue_empty)
    );

    // Compare the head prediction with the actual outcome and pick the correct next pc.
    always_comb begin
        wrong      = (ex_taken != head_pred_taken)
                   | (ex_taken & head_pred_taken & (ex_target != head_target));
        mispredict = pop_ok & wrong;
        fix_pc     = ex_taken ? ex_target : head_pc + PC_W'(PC_INC);
    end

    // Registered predictor update, redirect pulse and sticky underflow flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            past_pc              <= '0;
            past_is_branch       <= 1'b0;
            past_wrong           <= 1'b0;
            past_predicted_taken <= 1'b0;
            redirect_valid       <= 1'b0;
            redirect_pc          <= '0;
            underflow_err        <= 1'b0;
        end else begin
            past_is_branch <= pop_ok;
            redirect_valid <= mispredict;
            if (pop_ok) begin
                past_pc              <= head_pc;
                past_wrong           <= wrong;
                past_predicted_taken <= head_pred_taken;
            end
            if (mispredict) begin
                redirect_pc <= fix_pc;
            end
            if (ex_resolve && queue_empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (DEPTH=4, PC_W=32, PC_INC=1).
module tb_branch_resolver;

    logic        clock;
    logic        reset;
    logic        dec_push;
    logic [31:0] dec_pc;
    logic        dec_pred_taken;
    logic [31:0] dec_pred_target;
    logic        ex_resolve;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] past_pc;
    logic        past_is_branch;
    logic        past_wrong;
    logic        past_predicted_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        queue_full;
    logic        queue_empty;
    logic        underflow_err;

    int n_compared;
    int n_mismatched;

    branch_resolver #(
        .DEPTH  (4),
        .PC_W   (32),
        .PC_INC (1)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .dec_push             (dec_push),
        .dec_pc               (dec_pc),
        .dec_pred_taken       (dec_pred_taken),
        .dec_pred_target      (dec_pred_target),
        .ex_resolve           (ex_resolve),
        .ex_taken             (ex_taken),
        .ex_target            (ex_target),
        .past_pc              (past_pc),
        .past_is_branch       (past_is_branch),
        .past_wrong           (past_wrong),
        .past_predicted_taken (past_predicted_taken),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .queue_full           (queue_full),
        .queue_empty          (queue_empty),
        .underflow_err        (underflow_err)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of decode/execute inputs, then sample 1 ns after the edge.
    task automatic apply_stimulus(input logic push, input logic [31:0] pc, input logic pt,
                                  input logic [31:0] ptgt, input logic res, input logic tk,
                                  input logic [31:0] tgt);
        dec_push        = push;
        dec_pc          = pc;
        dec_pred_taken  = pt;
        dec_pred_target = ptgt;
        ex_resolve      = res;
        ex_taken        = tk;
        ex_target       = tgt;
        @(posedge clock);
        #1;
        dec_push   = 1'b0;
        ex_resolve = 1'b0;
    endtask

    // Reset held low with decode pushing: everything must come up idle.
    task automatic test_reset();
        reset = 1'b0;
        apply_stimulus(1'b1, 32'h5, 1'b1, 32'h9, 1'b1, 1'b0, 32'h0);
        reset = 1'b0;
        apply_stimulus(1'b1, 32'h6, 1'b1, 32'h9, 1'b0, 1'b0, 32'h0);
        n_compared++; if (queue_empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_empty: got %b expected 1", queue_empty); end
        n_compared++; if (queue_full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_full: got %b expected 0", queue_full); end
        n_compared++; if (past_is_branch !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_past_is_branch: got %b expected 0", past_is_branch); end
        n_compared++; if (redirect_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_redirect_valid: got %b expected 0", redirect_valid); end
        n_compared++; if (underflow_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_underflow: got %b expected 0", underflow_err); end
        n_compared++; if (redirect_pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
        reset = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_compared++; if (queue_empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL release_empty: got %b expected 1", queue_empty); end
    endtask

    // Taken prediction with correct target resolves without redirect.
    task automatic test_correct();
        apply_stimulus(1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
        n_compared++; if (queue_empty !== 1'b0) begin n_mismatched++; $display("[TB] FAIL correct_not_empty: got %b expected 0", queue_empty); end
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
        n_compared++; if (past_is_branch !== 1'b1) begin n_mismatched++; $display("[TB] FAIL correct_is_branch: got %b expected 1", past_is_branch); end
        n_compared++; if (past_pc !== 32'h10) begin n_mismatched++; $display("[TB] FAIL correct_past_pc: got %h expected 00000010", past_pc); end
        n_compared++; if (past_wrong !== 1'b0) begin n_mismatched++; $display("[TB] FAIL correct_wrong: got %b expected 0", past_wrong); end
        n_compared++; if (past_predicted_taken !== 1'b1) begin n_mismatched++; $display("[TB] FAIL correct_pred_taken: got %b expected 1", past_predicted_taken); end
        n_compared++; if (redirect_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL correct_redirect: got %b expected 0", redirect_valid); end
        n_compared++; if (queue_empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL correct_empty: got %b expected 1", queue_empty); end
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_compared++; if (past_is_branch !== 1'b0) begin n_mismatched++; $display("[TB] FAIL correct_pulse_end: got %b expected 0", past_is_branch); end
        n_compared++; if (past_pc !== 32'h10) begin n_mismatched++; $display("[TB] FAIL correct_pc_hold: got %h expected 00000010", past_pc); end
    endtask

    // Predicted taken, actually not taken: redirect to fall-through and flush younger entry.
    task automatic test_direction_mispredict();
        apply_stimulus(1'b1, 32'h20, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b1, 32'h21, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h99);
        n_compared++; if (past_is_branch !== 1'b1) begin n_mismatched++; $display("[TB] FAIL dir_is_branch: got %b expected 1", past_is_branch); end
        n_compared++; if (past_pc !== 32'h20) begin n_mismatched++; $display("[TB] FAIL dir_past_pc: got %h expected 00000020", past_pc); end
        n_compared++; if (past_wrong !== 1'b1) begin n_mismatched++; $display("[TB] FAIL dir_wrong: got %b expected 1", past_wrong); end
        n_compared++; if (redirect_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL dir_redirect: got %b expected 1", redirect_valid); end
        n_compared++; if (redirect_pc !== 32'h21) begin n_mismatched++; $display("[TB] FAIL dir_redirect_pc: got %h expected 00000021", redirect_pc); end
        n_compared++; if (queue_empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL dir_flushed: got %b expected 1", queue_empty); end
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_compared++; if (redirect_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL dir_pulse_end: got %b expected 0", redirect_valid); end
    endtask

    // Right direction, wrong target; a same-cycle push is wrong-path and must vanish.
    task automatic test_target_mispredict();
        apply_stimulus(1'b1, 32'h30, 1'b1, 32'h50, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b1, 32'h31, 1'b0, 32'h0, 1'b1, 1'b1, 32'h60);
        n_compared++; if (past_wrong !== 1'b1) begin n_mismatched++; $display("[TB] FAIL tgt_wrong: got %b expected 1", past_wrong); end
        n_compared++; if (redirect_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL tgt_redirect: got %b expected 1", redirect_valid); end
        n_compared++; if (redirect_pc !== 32'h60) begin n_mismatched++; $display("[TB] FAIL tgt_redirect_pc: got %h expected 00000060", redirect_pc); end
        n_compared++; if (queue_empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL tgt_push_discarded: got %b expected 1", queue_empty); end
    endtask

    // Fill to DEPTH, drop an overflow push, push+pop while full, then drain in order across the wrap.
    task automatic test_full_wrap();
        logic [31:0] exp_pc [5];
        logic        exp_pt [5];
        exp_pc = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h105};
        exp_pt = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, exp_pc[i], exp_pt[i], 32'h200 + exp_pc[i], 1'b0, 1'b0, 32'h0);
        end
        n_compared++; if (queue_full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wrap_full: got %b expected 1", queue_full); end
        apply_stimulus(1'b1, 32'h104, 1'b1, 32'h304, 1'b0, 1'b0, 32'h0);
        n_compared++; if (queue_full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wrap_drop_full: got %b expected 1", queue_full); end
        n_compared++; if (past_is_branch !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wrap_drop_no_pulse: got %b expected 0", past_is_branch); end
        // Head 0x100 predicted not taken; a junk target must not count as wrong.
        apply_stimulus(1'b1, 32'h105, 1'b1, 32'h305, 1'b1, 1'b0, 32'hDEAD);
        n_compared++; if (past_pc !== 32'h100) begin n_mismatched++; $display("[TB] FAIL wrap_pushpop_pc: got %h expected 00000100", past_pc); end
        n_compared++; if (past_wrong !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wrap_nt_target_ignored: got %b expected 0", past_wrong); end
        n_compared++; if (queue_full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wrap_pushpop_full: got %b expected 1", queue_full); end
        for (int i = 1; i < 5; i++) begin
            apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, exp_pt[i], 32'h200 + exp_pc[i]);
            n_compared++; if (past_pc !== exp_pc[i] || past_is_branch !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wrap_drain_%0d: got pc %h valid %b expected pc %h valid 1", i, past_pc, past_is_branch, exp_pc[i]); end
            n_compared++; if (past_wrong !== 1'b0 || past_predicted_taken !== exp_pt[i]) begin n_mismatched++; $display("[TB] FAIL wrap_drain_pred_%0d: got wrong %b pt %b expected wrong 0 pt %b", i, past_wrong, past_predicted_taken, exp_pt[i]); end
        end
        n_compared++; if (queue_empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wrap_drained: got %b expected 1", queue_empty); end
    endtask

    // Resolve on empty is sticky-flagged with no pulse; fall-through pc wraps to zero.
    task automatic test_underflow_pc_wrap();
        apply_stimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1234, 1'b1, 1'b1, 32'h0);
        n_compared++; if (underflow_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL under_set: got %b expected 1", underflow_err); end
        n_compared++; if (past_is_branch !== 1'b0 || redirect_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL under_no_pulse: got %b%b expected 00", past_is_branch, redirect_valid); end
        n_compared++; if (queue_empty !== 1'b0) begin n_mismatched++; $display("[TB] FAIL under_push_kept: got %b expected 0", queue_empty); end
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        n_compared++; if (redirect_valid !== 1'b1 || past_wrong !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pcwrap_mispredict: got rv %b wrong %b expected 1 1", redirect_valid, past_wrong); end
        n_compared++; if (redirect_pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL pcwrap_redirect_pc: got %h expected 00000000", redirect_pc); end
        n_compared++; if (underflow_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL under_sticky: got %b expected 1", underflow_err); end
    endtask

    // Reset in the middle of activity drops queued entries and clears the sticky flag.
    task automatic test_mid_reset();
        apply_stimulus(1'b1, 32'h77, 1'b1, 32'h88, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        n_compared++; if (queue_empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_empty: got %b expected 1", queue_empty); end
        n_compared++; if (underflow_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_underflow: got %b expected 0", underflow_err); end
        n_compared++; if (past_pc !== 32'h0 || redirect_pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL midreset_regs: got past_pc %h redirect_pc %h expected 0 0", past_pc, redirect_pc); end
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h88);
        n_compared++; if (past_is_branch !== 1'b0 || underflow_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_discarded: got valid %b underflow %b expected 0 1", past_is_branch, underflow_err); end
    endtask

    // Run every scenario in order and report.
    initial begin
        n_compared      = 0;
        n_mismatched    = 0;
        reset           = 1'b0;
        dec_push        = 1'b0;
        dec_pc          = '0;
        dec_pred_taken  = 1'b0;
        dec_pred_target = '0;
        ex_resolve      = 1'b0;
        ex_taken        = 1'b0;
        ex_target       = '0;
        $display("[TB] starting branch_resolver bench");
        test_reset();
        test_correct();
        test_direction_mispredict();
        test_target_mispredict();
        test_full_wrap();
        test_underflow_pc_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
